// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: stores bytes tagged with a header marker
// and tracks the remaining packet length on the read side.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             write_en,
  input  logic             read_en,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             wr_drop
);

  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [6:0]       pkt_cnt;
  logic [WIDTH:0]   rd_word;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_ok   = write_en && !full;
  assign rd_ok   = read_en && !empty;
  assign rd_word = mem[rd_ptr[PTR_W-1:0]];

  // Storage carries no reset; contents are don't-care after rst or soft_rst.
  always_ff @(posedge clk) begin
    if (wr_ok && !soft_rst)
      mem[wr_ptr[PTR_W-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
      wr_drop  <= 1'b0;
    end else if (soft_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= write_en && full;
      if (wr_ok)
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + (PTR_W+1)'(1);
        data_out <= rd_word[WIDTH-1:0];
        // Header byte: payload length field plus one parity byte.
        if (rd_word[WIDTH])
          pkt_cnt <= 7'(rd_word[7:2]) + 7'd1;
        else if (pkt_cnt != 7'd0)
          pkt_cnt <= pkt_cnt - 7'd1;
      end else if (pkt_cnt == 7'd0) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: table-driven packet vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_router_fifo;

  logic       clk;
  logic       rst;
  logic       soft_rst;
  logic       write_en;
  logic       read_en;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       wr_drop;

  int nerr = 0;
  int nchk = 0;

  router_fifo #(.WIDTH(8), .DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .write_en(write_en),
    .read_en(read_en), .lfd_state(lfd_state), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of {lfd, byte} plus the observable registers.
  logic [8:0] q[$];
  int         m_cnt;
  logic [7:0] m_dout;
  logic       m_drop;

  task automatic model_clear();
    q.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
    m_drop = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic re, input logic lfd,
                            input logic [7:0] din, input logic srst);
    logic       is_full;
    logic       is_empty;
    logic [8:0] w;
    if (srst) begin
      model_clear();
      return;
    end
    is_full  = (q.size() == 16);
    is_empty = (q.size() == 0);
    m_drop   = we && is_full;
    if (re && !is_empty) begin
      w      = q.pop_front();
      m_dout = w[7:0];
      if (w[8])          m_cnt = int'(w[7:2]) + 1;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end else if (m_cnt == 0) begin
      m_dout = 8'h00;
    end
    if (we && !is_full) q.push_back({lfd, din});
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " full"},     int'(full),        int'(q.size() == 16));
    chk({tag, " empty"},    int'(empty),       int'(q.size() == 0));
    chk({tag, " data_out"}, int'(data_out),    int'(m_dout));
    chk({tag, " wr_drop"},  int'(wr_drop),     int'(m_drop));
    chk({tag, " pkt_cnt"},  int'(dut.pkt_cnt), m_cnt);
  endtask

  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic [7:0] din, input logic srst);
    write_en  = we;
    read_en   = re;
    lfd_state = lfd;
    data_in   = din;
    soft_rst  = srst;
    @(posedge clk);
    model_edge(we, re, lfd, din, srst);
    #1;
  endtask

  task automatic do_reset();
    write_en = 1'b0; read_en = 1'b0; soft_rst = 1'b0;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run(input string tag, input int n, input logic we, input logic re,
                     input logic lfd, input logic rnd_data);
    for (int i = 0; i < n; i++) begin
      step(we, re, lfd, rnd_data ? 8'($urandom) : 8'(i + 1), 1'b0);
      check_model(tag);
    end
  endtask

  typedef struct {
    logic       we;
    logic       re;
    logic       lfd;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_empty;
    int         exp_cnt;
  } vec_t;

  vec_t vt[11];

  initial begin
    // T2 packet vectors; expectations are post-edge values.
    vt[0]  = '{1'b1, 1'b0, 1'b1, 8'h0A, 8'h00, 1'b0, 0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0, 0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0A, 1'b0, 3};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0, 2};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 1'b0, 1};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 1'b1, 0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 0};

    rst = 1'b1; soft_rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    do_reset();
    chk("reset full",     int'(full),     0);
    chk("reset empty",    int'(empty),    1);
    chk("reset data_out", int'(data_out), 0);
    chk("reset wr_drop",  int'(wr_drop),  0);

    // T2: table-driven packet
    for (int i = 0; i < 11; i++) begin
      step(vt[i].we, vt[i].re, vt[i].lfd, vt[i].din, 1'b0);
      chk($sformatf("vec%0d data_out", i), int'(data_out),    int'(vt[i].exp_dout));
      chk($sformatf("vec%0d empty", i),    int'(empty),       int'(vt[i].exp_empty));
      chk($sformatf("vec%0d full", i),     int'(full),        0);
      chk($sformatf("vec%0d pkt_cnt", i),  int'(dut.pkt_cnt), vt[i].exp_cnt);
    end

    // T1: async reset mid-write while data_out is non-zero
    step(1'b1, 1'b0, 1'b1, 8'hFC, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
    check_model("t1 pre");
    write_en = 1'b1; data_in = 8'h66;
    #2;
    rst = 1'b1;
    #1;
    chk("t1 async full",     int'(full),     0);
    chk("t1 async empty",    int'(empty),    1);
    chk("t1 async data_out", int'(data_out), 0);
    chk("t1 async pkt_cnt",  int'(dut.pkt_cnt), 0);
    do_reset();
    check_model("t1 post");

    // T3: fill, overflow, read+write while full, drain in order
    run("t3 fill", 16, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3 full after 16", int'(full), 1);
    step(1'b1, 1'b0, 1'b0, 8'hEE, 1'b0);
    check_model("t3 overflow");
    chk("t3 wr_drop pulse", int'(wr_drop), 1);
    step(1'b1, 1'b1, 1'b0, 8'hDD, 1'b0);
    check_model("t3 rw full");
    run("t3 drain", 17, 1'b0, 1'b1, 1'b0, 1'b0);

    // T4: pointer wrap
    do_reset();
    run("t4 w10", 10, 1'b1, 1'b0, 1'b0, 1'b1);
    run("t4 r10", 10, 1'b0, 1'b1, 1'b0, 1'b0);
    run("t4 w16", 16, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4 full", int'(full), 1);
    run("t4 r16", 16, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4 empty", int'(empty), 1);

    // T5: simultaneous read/write at occupancy 5, then at empty
    do_reset();
    run("t5 w5", 5, 1'b1, 1'b0, 1'b0, 1'b1);
    run("t5 rw", 8, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5 occupancy", q.size(), 5);
    run("t5 drain", 5, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
    check_model("t5 rw empty");
    chk("t5 not empty", int'(empty), 0);
    run("t5 last", 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // T6: soft reset mid-packet, then a clean packet
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'h14, 1'b0);
    run("t6 w5", 5, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_model("t6 rd hdr");
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    check_model("t6 soft_rst");
    chk("t6 empty", int'(empty), 1);
    step(1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
    run("t6 payload", 2, 1'b1, 1'b0, 1'b0, 1'b1);
    run("t6 read", 4, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 7) == 0), 8'($urandom),
           1'($urandom_range(0, 199) == 0));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
